// File: rtl/dijkstra_relax_pkg.sv
// Shared definitions for the Dijkstra relaxation datapath.
// Cost width, INF cost, FSM encodings and the saturating add.
package dijkstra_relax_pkg;

    localparam int DIJ_W_D = 32;

    localparam logic [DIJ_W_D-1:0] INF_COST = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_COMPARE = 3'd2,
        ST_PUSH    = 3'd3,
        ST_DONE    = 3'd4
    } relax_state_t;

    function automatic logic [DIJ_W_D-1:0] sat_add(
        input logic [DIJ_W_D-1:0] a,
        input logic [DIJ_W_D-1:0] b
    );
        logic [DIJ_W_D:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DIJ_W_D] ? INF_COST : s[DIJ_W_D-1:0];
    endfunction

endpackage

// File: rtl/dijkstra_relax.sv
// Edge relaxation for one popped source node: read dst cost,
// write back and push to the frontier on strict improvement.
module dijkstra_relax
    import dijkstra_relax_pkg::*;
#(
    parameter int W_D = DIJ_W_D
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           start,
    input  logic [W_D-1:0] src_cost,
    input  logic [W_D-1:0] src_num_edges,
    input  logic           edge_valid,
    output logic           edge_ready,
    input  logic [W_D-1:0] edge_dst_addr,
    input  logic [W_D-1:0] edge_weight,
    output logic           cost_rd_en,
    output logic [W_D-1:0] cost_rd_addr,
    input  logic [W_D-1:0] cost_rd_data,
    output logic           cost_wr_en,
    output logic [W_D-1:0] cost_wr_addr,
    output logic [W_D-1:0] cost_wr_data,
    output logic           fr_write_valid,
    input  logic           fr_write_ready,
    output logic [W_D-1:0] fr_node_addr,
    output logic [W_D-1:0] fr_cost,
    output logic           busy,
    output logic           done,
    output logic [W_D-1:0] push_count
);

    relax_state_t   state_q;
    relax_state_t   state_d;
    logic [W_D-1:0] src_cost_q;
    logic [W_D-1:0] remaining_q;
    logic [W_D-1:0] dst_q;
    logic [W_D-1:0] weight_q;
    logic [W_D-1:0] cand_q;
    logic [W_D-1:0] push_count_q;
    logic [W_D:0]   sum_c;
    logic [W_D-1:0] cand_c;
    logic           improve_c;
    logic           last_c;

    // Candidate cost saturates so an overflow never wraps below a real cost.
    always_comb begin
        sum_c     = {1'b0, src_cost_q} + {1'b0, weight_q};
        cand_c    = sum_c[W_D] ? '1 : sum_c[W_D-1:0];
        improve_c = (cand_c < cost_rd_data);
        last_c    = (remaining_q == W_D'(1));
    end

    // Next-state and state-decoded handshake/strobe outputs.
    always_comb begin
        state_d        = state_q;
        edge_ready     = 1'b0;
        cost_rd_en     = 1'b0;
        cost_rd_addr   = '0;
        cost_wr_en     = 1'b0;
        cost_wr_addr   = '0;
        cost_wr_data   = '0;
        fr_write_valid = 1'b0;
        fr_node_addr   = '0;
        fr_cost        = '0;
        done           = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (src_num_edges == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                edge_ready = 1'b1;
                if (edge_valid) begin
                    cost_rd_en   = 1'b1;
                    cost_rd_addr = edge_dst_addr;
                    state_d      = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (improve_c) begin
                    cost_wr_en   = 1'b1;
                    cost_wr_addr = dst_q;
                    cost_wr_data = cand_c;
                    state_d      = ST_PUSH;
                end else if (last_c) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_PUSH: begin
                fr_write_valid = 1'b1;
                fr_node_addr   = dst_q;
                fr_cost        = cand_q;
                if (fr_write_ready) begin
                    state_d = last_c ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register plus per-node latches; start is only honoured in IDLE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            src_cost_q   <= '0;
            remaining_q  <= '0;
            dst_q        <= '0;
            weight_q     <= '0;
            cand_q       <= '0;
            push_count_q <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        src_cost_q   <= src_cost;
                        remaining_q  <= src_num_edges;
                        push_count_q <= '0;
                    end
                end
                ST_FETCH: begin
                    if (edge_valid) begin
                        dst_q    <= edge_dst_addr;
                        weight_q <= edge_weight;
                    end
                end
                ST_COMPARE: begin
                    if (improve_c) begin
                        cand_q <= cand_c;
                    end else begin
                        remaining_q <= remaining_q - W_D'(1);
                    end
                end
                ST_PUSH: begin
                    if (fr_write_ready) begin
                        push_count_q <= push_count_q + W_D'(1);
                        remaining_q  <= remaining_q - W_D'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign push_count = push_count_q;

endmodule

// File: tb/tb_dijkstra_relax.sv
// Directed bench for dijkstra_relax with a write-back cost memory model.
// Inputs change 1ns after posedge; outputs are checked 2ns after posedge.
module tb_dijkstra_relax;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [31:0] src_cost;
    logic [31:0] src_num_edges;
    logic        edge_valid;
    logic        edge_ready;
    logic [31:0] edge_dst_addr;
    logic [31:0] edge_weight;
    logic        cost_rd_en;
    logic [31:0] cost_rd_addr;
    logic [31:0] cost_rd_data;
    logic        cost_wr_en;
    logic [31:0] cost_wr_addr;
    logic [31:0] cost_wr_data;
    logic        fr_write_valid;
    logic        fr_write_ready;
    logic [31:0] fr_node_addr;
    logic [31:0] fr_cost;
    logic        busy;
    logic        done;
    logic [31:0] push_count;

    int vectors = 0;
    int errs    = 0;

    logic [31:0] mem [16];

    always #5 CLK = ~CLK;

    dijkstra_relax #(.W_D(32)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .start          (start),
        .src_cost       (src_cost),
        .src_num_edges  (src_num_edges),
        .edge_valid     (edge_valid),
        .edge_ready     (edge_ready),
        .edge_dst_addr  (edge_dst_addr),
        .edge_weight    (edge_weight),
        .cost_rd_en     (cost_rd_en),
        .cost_rd_addr   (cost_rd_addr),
        .cost_rd_data   (cost_rd_data),
        .cost_wr_en     (cost_wr_en),
        .cost_wr_addr   (cost_wr_addr),
        .cost_wr_data   (cost_wr_data),
        .fr_write_valid (fr_write_valid),
        .fr_write_ready (fr_write_ready),
        .fr_node_addr   (fr_node_addr),
        .fr_cost        (fr_cost),
        .busy           (busy),
        .done           (done),
        .push_count     (push_count)
    );

    // Cost memory: 1-cycle read latency, write visible to later reads.
    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hFFFF_FFFF;
            mem[4]       <= 32'd15;
            mem[5]       <= 32'd100;
            cost_rd_data <= '0;
        end else begin
            if (cost_rd_en) cost_rd_data <= mem[cost_rd_addr[3:0]];
            if (cost_wr_en) mem[cost_wr_addr[3:0]] <= cost_wr_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic accept_edge(input logic [31:0] d, input logic [31:0] w);
        edge_valid    = 1'b1;
        edge_dst_addr = d;
        edge_weight   = w;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (edge_ready) begin
                chk("rd_en", {31'd0, cost_rd_en}, 32'd1);
                chk("rd_addr", cost_rd_addr, d);
                tick();
                edge_valid = 1'b0;
                return;
            end
            tick();
        end
        edge_valid = 1'b0;
        vectors++;
        errs++;
        $error("FAIL edge_timeout observed=no_ready expected=ready");
    endtask

    initial begin
        RST            = 1'b1;
        start          = 1'b0;
        src_cost       = '0;
        src_num_edges  = '0;
        edge_valid     = 1'b0;
        edge_dst_addr  = '0;
        edge_weight    = '0;
        fr_write_ready = 1'b1;

        tick();
        tick();
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_eready", {31'd0, edge_ready}, 32'd0);
        chk("rst_frv", {31'd0, fr_write_valid}, 32'd0);
        chk("rst_rd", {31'd0, cost_rd_en}, 32'd0);
        chk("rst_wr", {31'd0, cost_wr_en}, 32'd0);
        chk("rst_pc", push_count, 32'd0);
        RST = 1'b0;
        tick();

        // 1: improvement over INF, cost 5+2 to node 3
        src_cost      = 32'd5;
        src_num_edges = 32'd1;
        start         = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_eready", {31'd0, edge_ready}, 32'd1);
        accept_edge(32'd3, 32'd2);
        #1;
        chk("t1_wr_en", {31'd0, cost_wr_en}, 32'd1);
        chk("t1_wr_addr", cost_wr_addr, 32'd3);
        chk("t1_wr_data", cost_wr_data, 32'd7);
        tick();
        #1;
        chk("t1_frv", {31'd0, fr_write_valid}, 32'd1);
        chk("t1_fr_node", fr_node_addr, 32'd3);
        chk("t1_fr_cost", fr_cost, 32'd7);
        tick();
        #1;
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_done_busy", {31'd0, busy}, 32'd1);
        chk("t1_pc", push_count, 32'd1);
        tick();
        #1;
        chk("t1_idle_done", {31'd0, done}, 32'd0);
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);

        // 2: cand 10+5 equals stored 15, no write, no push
        src_cost      = 32'd10;
        src_num_edges = 32'd1;
        start         = 1'b1;
        tick();
        start = 1'b0;
        accept_edge(32'd4, 32'd5);
        #1;
        chk("t2_wr_en", {31'd0, cost_wr_en}, 32'd0);
        tick();
        #1;
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_frv", {31'd0, fr_write_valid}, 32'd0);
        chk("t2_pc", push_count, 32'd0);
        tick();

        // 3: zero edges goes straight to DONE
        src_num_edges = 32'd0;
        start         = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_eready", {31'd0, edge_ready}, 32'd0);
        chk("t3_busy", {31'd0, busy}, 32'd1);
        tick();
        #1;
        chk("t3_idle", {31'd0, busy}, 32'd0);

        // 4: saturated cand against INF in both slots
        src_cost      = 32'hFFFF_FFF0;
        src_num_edges = 32'd2;
        start         = 1'b1;
        tick();
        start = 1'b0;
        accept_edge(32'd1, 32'h20);
        #1;
        chk("t4a_wr_en", {31'd0, cost_wr_en}, 32'd0);
        tick();
        accept_edge(32'd2, 32'h20);
        #1;
        chk("t4b_wr_en", {31'd0, cost_wr_en}, 32'd0);
        tick();
        #1;
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_pc", push_count, 32'd0);
        tick();

        // 4c: just below saturation still beats INF
        src_cost      = 32'hFFFF_FFF0;
        src_num_edges = 32'd1;
        start         = 1'b1;
        tick();
        start = 1'b0;
        accept_edge(32'd6, 32'h0E);
        #1;
        chk("t4c_wr_en", {31'd0, cost_wr_en}, 32'd1);
        chk("t4c_wr_data", cost_wr_data, 32'hFFFF_FFFE);
        tick();
        #1;
        chk("t4c_fr_cost", fr_cost, 32'hFFFF_FFFE);
        tick();
        #1;
        chk("t4c_pc", push_count, 32'd1);
        tick();

        // 5: frontier stall with a stray start and pending edge
        fr_write_ready = 1'b0;
        src_cost       = 32'd0;
        src_num_edges  = 32'd1;
        start          = 1'b1;
        tick();
        start = 1'b0;
        accept_edge(32'd5, 32'd9);
        #1;
        chk("t5_wr_en", {31'd0, cost_wr_en}, 32'd1);
        tick();
        edge_valid    = 1'b1;
        edge_dst_addr = 32'd8;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t5_frv", {31'd0, fr_write_valid}, 32'd1);
            chk("t5_node", fr_node_addr, 32'd5);
            chk("t5_cost", fr_cost, 32'd9);
            chk("t5_eready", {31'd0, edge_ready}, 32'd0);
            chk("t5_rd_en", {31'd0, cost_rd_en}, 32'd0);
            if (i == 3) begin
                start         = 1'b1;
                src_cost      = 32'd77;
                src_num_edges = 32'd0;
            end
            tick();
            start = 1'b0;
        end
        edge_valid     = 1'b0;
        fr_write_ready = 1'b1;
        #1;
        chk("t5_frv_last", {31'd0, fr_write_valid}, 32'd1);
        tick();
        #1;
        chk("t5_done", {31'd0, done}, 32'd1);
        chk("t5_pc", push_count, 32'd1);
        tick();

        // 6: duplicate dst sees written-back cost, then reset mid-push
        src_cost      = 32'd1;
        src_num_edges = 32'd2;
        start         = 1'b1;
        tick();
        start = 1'b0;
        accept_edge(32'd7, 32'd4);
        #1;
        chk("t6a_wr_data", cost_wr_data, 32'd5);
        tick();
        #1;
        chk("t6a_node", fr_node_addr, 32'd7);
        chk("t6a_cost", fr_cost, 32'd5);
        tick();
        accept_edge(32'd7, 32'd2);
        #1;
        chk("t6b_wr_en", {31'd0, cost_wr_en}, 32'd1);
        chk("t6b_wr_data", cost_wr_data, 32'd3);
        fr_write_ready = 1'b0;
        tick();
        #1;
        chk("t6b_node", fr_node_addr, 32'd7);
        chk("t6b_cost", fr_cost, 32'd3);
        chk("t6b_pc", push_count, 32'd1);
        RST = 1'b1;
        tick();
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_frv", {31'd0, fr_write_valid}, 32'd0);
        chk("t6_rst_cost", fr_cost, 32'd0);
        chk("t6_rst_pc", push_count, 32'd0);
        chk("t6_rst_done", {31'd0, done}, 32'd0);
        chk("t6_rst_wr", {31'd0, cost_wr_en}, 32'd0);
        RST = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
